// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_trace_buffer
//  Purpose  : Captures architecturally visible register-file writes from the
//             core's writeback debug port into a FIFO and drains them over a
//             valid/ready stream. Events arriving while full are dropped and
//             counted (saturating) with a sticky overflow flag.
//  Options  : WB_TRACE_TIMESTAMP_EN - when defined, every entry carries the
//             value of a free-running 32-bit cycle counter sampled in its
//             push cycle. When undefined, io_out_ts is tied to 0.
//  Ports    : clock, reset          - core clock, sync active-high reset
//             io_en                 - capture enable
//             io_debug_pc/wen/waddr/wdata - writeback event in
//             io_out_valid/ready    - drain handshake
//             io_out_pc/wen/waddr/wdata/ts - head entry
//             io_count              - occupancy (0..DEPTH)
//             io_drop_cnt           - dropped events, saturating
//             io_overflow           - sticky drop flag
//             io_clr_overflow       - clears io_overflow and io_drop_cnt
//  Revision : 1.0 - initial release
// ============================================================================
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_en,
    input  logic [31:0]              io_debug_pc,
    input  logic [3:0]               io_debug_wen,
    input  logic [4:0]               io_debug_waddr,
    input  logic [31:0]              io_debug_wdata,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [31:0]              io_out_pc,
    output logic [3:0]               io_out_wen,
    output logic [4:0]               io_out_waddr,
    output logic [31:0]              io_out_wdata,
    output logic [31:0]              io_out_ts,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic [CNT_W-1:0]         io_drop_cnt,
    output logic                     io_overflow,
    input  logic                     io_clr_overflow
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    logic [31:0] mem_pc    [DEPTH];
    logic [3:0]  mem_wen   [DEPTH];
    logic [4:0]  mem_waddr [DEPTH];
    logic [31:0] mem_wdata [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic accept;
    logic drop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push   = io_en && (io_debug_wen != 4'd0) && (io_debug_waddr != 5'd0);
    assign pop    = !empty && io_out_ready;
    // A simultaneous pop frees the slot the push needs, so full only drops
    // when the sink is not taking the head this cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Clear has priority over a drop in the same cycle.
            if (io_clr_overflow) begin
                drop_cnt <= '0;
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {CNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: contents are only observed behind the pointers.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem_pc[wr_ptr[AW-1:0]]    <= io_debug_pc;
            mem_wen[wr_ptr[AW-1:0]]   <= io_debug_wen;
            mem_waddr[wr_ptr[AW-1:0]] <= io_debug_waddr;
            mem_wdata[wr_ptr[AW-1:0]] <= io_debug_wdata;
        end
    end

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] mem_ts [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt <= 32'd0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem_ts[wr_ptr[AW-1:0]] <= ts_cnt;
        end
    end

    assign io_out_ts = mem_ts[rd_ptr[AW-1:0]];
`else
    assign io_out_ts = 32'd0;
`endif

    assign io_out_valid = !empty;
    assign io_out_pc    = mem_pc[rd_ptr[AW-1:0]];
    assign io_out_wen   = mem_wen[rd_ptr[AW-1:0]];
    assign io_out_waddr = mem_waddr[rd_ptr[AW-1:0]];
    assign io_out_wdata = mem_wdata[rd_ptr[AW-1:0]];
    assign io_count     = wr_ptr - rd_ptr;
    assign io_drop_cnt  = drop_cnt;
    assign io_overflow  = overflow;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_trace_buffer
//  Purpose  : Self-checking bench for wb_trace_buffer. A queue-based model of
//             the trace FIFO predicts occupancy, head entry, drop count and
//             overflow flag; directed scenarios are followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_en;
    logic [31:0]       io_debug_pc;
    logic [3:0]        io_debug_wen;
    logic [4:0]        io_debug_waddr;
    logic [31:0]       io_debug_wdata;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [31:0]       io_out_pc;
    logic [3:0]        io_out_wen;
    logic [4:0]        io_out_waddr;
    logic [31:0]       io_out_wdata;
    logic [31:0]       io_out_ts;
    logic [CW-1:0]     io_count;
    logic [CNT_W-1:0]  io_drop_cnt;
    logic              io_overflow;
    logic              io_clr_overflow;

    wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_en          (io_en),
        .io_debug_pc    (io_debug_pc),
        .io_debug_wen   (io_debug_wen),
        .io_debug_waddr (io_debug_waddr),
        .io_debug_wdata (io_debug_wdata),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_pc      (io_out_pc),
        .io_out_wen     (io_out_wen),
        .io_out_waddr   (io_out_waddr),
        .io_out_wdata   (io_out_wdata),
        .io_out_ts      (io_out_ts),
        .io_count       (io_count),
        .io_drop_cnt    (io_drop_cnt),
        .io_overflow    (io_overflow),
        .io_clr_overflow(io_clr_overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] ts;
    } ent_t;

    ent_t q[$];
    int   m_drop;
    bit   m_ovf;
    int   m_ts;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply current inputs for one clock edge, advance the model, settle.
    task automatic cycle();
        bit   do_push;
        ent_t e;
        do_push = io_en && (io_debug_wen != 0) && (io_debug_waddr != 0);
        if (reset) begin
            q.delete();
            m_drop = 0;
            m_ovf  = 0;
            m_ts   = 0;
        end else begin
            if (q.size() != 0 && io_out_ready) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < DEPTH) begin
                    e.pc = io_debug_pc; e.wen = io_debug_wen; e.waddr = io_debug_waddr;
                    e.wdata = io_debug_wdata; e.ts = m_ts;
                    q.push_back(e);
                end else if (!io_clr_overflow) begin
                    m_ovf = 1;
                    if (m_drop < (1 << CNT_W) - 1) m_drop++;
                end
            end
            if (io_clr_overflow) begin
                m_drop = 0;
                m_ovf  = 0;
            end
            m_ts++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_state();
        chk("count", io_count, q.size());
        chk("valid", io_out_valid, q.size() != 0);
        chk("drop_cnt", io_drop_cnt, m_drop);
        chk("overflow", io_overflow, m_ovf);
        if (q.size() != 0) begin
            chk("out_pc", io_out_pc, q[0].pc);
            chk("out_wen", io_out_wen, q[0].wen);
            chk("out_waddr", io_out_waddr, q[0].waddr);
            chk("out_wdata", io_out_wdata, q[0].wdata);
`ifdef WB_TRACE_TIMESTAMP_EN
            chk("out_ts", io_out_ts, q[0].ts);
`else
            chk("out_ts", io_out_ts, 0);
`endif
        end
    endtask

    task automatic idle_inputs();
        reset = 0; io_en = 0; io_debug_pc = 0; io_debug_wen = 0;
        io_debug_waddr = 0; io_debug_wdata = 0; io_out_ready = 0; io_clr_overflow = 0;
    endtask

    task automatic set_event(input logic [31:0] pc, input logic [3:0] wen,
                             input logic [4:0] waddr, input logic [31:0] wdata);
        io_en = 1; io_debug_pc = pc; io_debug_wen = wen;
        io_debug_waddr = waddr; io_debug_wdata = wdata;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        check_state();
    endtask

    task automatic push_n(input int n, input logic ready);
        for (int i = 0; i < n; i++) begin
            set_event(32'h1000_0000 + i * 4, 4'hF, 5'(1 + (i % 31)), $urandom);
            io_out_ready = ready;
            cycle();
            check_state();
        end
        idle_inputs();
    endtask

    task automatic drain();
        io_out_ready = 1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle();
            check_state();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_drop = 0; m_ovf = 0; m_ts = 0;
        @(posedge clock);
        #1;

        // Reset state
        do_reset();
        chk("rst_count", io_count, 0);
        chk("rst_valid", io_out_valid, 0);

        // Single event, visible one cycle later, held until ready
        set_event(32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678);
        cycle();
        idle_inputs();
        chk("one_valid", io_out_valid, 1);
        chk("one_pc", io_out_pc, 32'hBFC0_0000);
        chk("one_wdata", io_out_wdata, 32'h1234_5678);
        chk("one_count", io_count, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_pc", io_out_pc, 32'hBFC0_0000);
            chk("hold_waddr", io_out_waddr, 8);
            check_state();
        end
        drain();

        // Filtered events: $0, wen=0, en=0
        set_event(32'h10, 4'hF, 5'd0, 32'hAA); cycle(); check_state();
        set_event(32'h14, 4'h0, 5'd3, 32'hBB); cycle(); check_state();
        set_event(32'h18, 4'hF, 5'd3, 32'hCC); io_en = 0; cycle(); check_state();
        idle_inputs();
        chk("filt_count", io_count, 0);
        chk("filt_valid", io_out_valid, 0);

        // Overflow: DEPTH+3 pushes with ready low
        push_n(DEPTH + 3, 1'b0);
        chk("ovf_count", io_count, DEPTH);
        chk("ovf_drop", io_drop_cnt, 3);
        chk("ovf_flag", io_overflow, 1);
        chk("ovf_head", io_out_pc, 32'h1000_0000);

        // Full with simultaneous push/pop: no drop, count unchanged
        set_event(32'hCAFE_0000, 4'h3, 5'd9, 32'h55); io_out_ready = 1;
        cycle();
        idle_inputs();
        chk("pp_count", io_count, DEPTH);
        chk("pp_drop", io_drop_cnt, 3);
        check_state();
        drain();

        // Clear wins over a simultaneous drop
        push_n(DEPTH, 1'b0);
        set_event(32'hDEAD_0000, 4'hF, 5'd4, 32'h77); io_clr_overflow = 1;
        cycle();
        idle_inputs();
        chk("clr_drop", io_drop_cnt, 0);
        chk("clr_flag", io_overflow, 0);
        check_state();
        drain();

        // Reset with 5 entries stored, sink ready during reset
        push_n(5, 1'b0);
        reset = 1; io_out_ready = 1;
        cycle();
        idle_inputs();
        chk("midrst_count", io_count, 0);
        chk("midrst_valid", io_out_valid, 0);
        check_state();

        // Timestamps: pushes in cycles 10 and 13 after reset release
        reset = 1; cycle(); reset = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 10 || c == 13) set_event(32'h2000 + c, 4'h1, 5'd5, c);
            else idle_inputs();
            cycle();
        end
        idle_inputs();
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts_first", io_out_ts, 10);
`else
        chk("ts_first", io_out_ts, 0);
`endif
        check_state();
        io_out_ready = 1; cycle(); io_out_ready = 0;
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts_second", io_out_ts, 13);
`else
        chk("ts_second", io_out_ts, 0);
`endif
        check_state();
        drain();

        // Random traffic with phases of different sink throughput
        for (int ph = 0; ph < 8; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 4) * 30;
            for (int i = 0; i < 400; i++) begin
                io_en           = ($urandom_range(0, 9) != 0);
                io_debug_pc     = $urandom;
                io_debug_wen    = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
                io_debug_waddr  = 5'($urandom);
                io_debug_wdata  = $urandom;
                io_out_ready    = ($urandom_range(0, 99) < rdy_pct);
                io_clr_overflow = ($urandom_range(0, 63) == 0);
                reset           = ($urandom_range(0, 499) == 0);
                cycle();
                check_state();
            end
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Downstream consumer of the core's writeback debug port (io_debug_pc/wen/waddr/wdata).
- Captures every architecturally visible register-file write into a FIFO.
- Drains captured events over a valid/ready stream to a trace checker or UART dumper.
- Decouples the bursty retire rate from a slower trace sink; counts events lost on overflow.

Parameters:
- DEPTH, 16: FIFO entries; power of two, >= 2.
- CNT_W, 16: width of the drop counter.

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- io_en  input  1  capture enable; 0 = ignore writeback events
- io_debug_pc  input  32  PC of the retiring instruction
- io_debug_wen  input  4  byte write enables of the regfile write
- io_debug_waddr  input  5  destination register number
- io_debug_wdata  input  32  written data
- io_out_valid  output  1  head entry available
- io_out_ready  input  1  sink accepts head this cycle
- io_out_pc  output  32  head entry PC
- io_out_wen  output  4  head entry byte enables
- io_out_waddr  output  5  head entry register number
- io_out_wdata  output  32  head entry data
- io_out_ts  output  32  head entry timestamp (see Optional Feature)
- io_count  output  log2(DEPTH)+1  current occupancy
- io_drop_cnt  output  CNT_W  events dropped while full, saturating
- io_overflow  output  1  sticky flag, set on any drop
- io_clr_overflow  input  1  clears io_overflow and io_drop_cnt

Behaviour:
- Reset (synchronous, active-high): rd/wr pointers = 0, io_count = 0, io_out_valid = 0, io_drop_cnt = 0, io_overflow = 0, timestamp counter = 0. Reset asserted mid-stream discards all entries; no output transaction completes in that cycle.
- Capture condition: push = io_en & (io_debug_wen != 0) & (io_debug_waddr != 0). Writes to $0 and cycles with wen == 0 are never stored.
- Entry = {pc, wen, waddr, wdata, ts}, sampled at the clock edge of the push cycle.
- Pop = io_out_valid & io_out_ready.
- Latency: an entry pushed at edge N is visible on io_out_* with io_out_valid = 1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass from input to output.
- io_out_* present the head entry combinationally from storage. Values are don't-care when io_out_valid = 0. While valid and not popped they must hold stable.
- io_out_valid = (io_count != 0).
- Pointers: log2(DEPTH)+1 bits with a wrap bit. Full when pointers are equal except for the MSB; empty when fully equal.
- Push with not full: store and increment wr pointer.
- Push with full and no pop: drop the event, increment io_drop_cnt (saturate at 2^CNT_W-1), set io_overflow.
- Push and pop in the same cycle while full: the pop frees a slot, so the push is accepted; no drop; io_count unchanged.
- Push and pop in the same cycle while empty: pop is impossible (valid = 0); push is accepted.
- Push and pop in the same cycle otherwise: io_count unchanged.
- io_clr_overflow and a drop in the same cycle: the clear wins; io_drop_cnt = 0 and io_overflow = 0 after the edge.
- Deasserting io_en does not affect draining of stored entries.
- All outputs are driven from registers or storage; no combinational path from io_debug_* to io_out_*.

Optional Feature:
- Macro WB_TRACE_TIMESTAMP_EN.
- Defined: a free-running 32-bit cycle counter increments every cycle after reset and wraps from 0xFFFFFFFF to 0. Each entry stores the counter value of its push cycle; io_out_ts returns it.
- Not defined: no counter and no timestamp storage; io_out_ts is tied to 0.

Test Plan:
- Reset, then push one event (pc=0xBFC00000, wen=0xF, waddr=8, wdata=0x12345678) with io_out_ready=0 -> io_out_valid=1 exactly one cycle later, same fields shown, io_count=1, holds until ready.
- Events with waddr=0, wen=0, or io_en=0 -> nothing stored; io_count stays 0; io_out_valid stays 0.
- DEPTH+3 consecutive pushes with ready=0 -> io_count=DEPTH, io_drop_cnt=3, io_overflow=1; drain yields the first DEPTH events in order.
- FIFO full, push and pop in the same cycle -> no drop, io_count stays DEPTH, new event appears last in the drain order.
- io_clr_overflow pulsed in the same cycle as a drop -> io_drop_cnt=0, io_overflow=0 next cycle. Reset asserted with 5 entries stored -> io_count=0 and io_out_valid=0 next cycle.
- With WB_TRACE_TIMESTAMP_EN: pushes issued in cycles 10 and 13 after reset release -> io_out_ts = 10 and 13. Without the macro -> io_out_ts = 0.
